// File: rtl/psum_pkg.sv
// psum_pkg: shared types, default sizes and saturating add for the psum collector
package psum_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;
  localparam int DEF_COLS = 14;
  localparam int DEF_ROWS = 12;
  localparam int DEF_PSUM_W = 32;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_SHIFT = 8;
  function automatic logic signed [31:0] sat_add32(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    return (s[32] != s[31]) ? (s[32] ? 32'sh8000_0000 : 32'sh7fff_ffff) : s[31:0];
  endfunction
endpackage

// File: rtl/psum_postproc.sv
// psum_postproc: per-lane ReLU, arithmetic right shift and unsigned saturation
module psum_postproc
  import psum_pkg::*;
#(
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic signed [PSUM_W-1:0] x,
  output logic        [OUT_W-1:0]  y
);
  logic signed [PSUM_W-1:0] s;
  always_comb begin
    s = x >>> SHIFT;
    y = x[PSUM_W-1] ? '0 : (|s[PSUM_W-1:OUT_W] ? '1 : s[OUT_W-1:0]);
  end
endmodule

// File: rtl/psum_collector.sv
// psum_collector: accumulates grid psum rows over passes and streams post-processed rows out
module psum_collector
  import psum_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [COLS-1:0][PSUM_W-1:0]  psum_outs,
  input  logic                         psum_valid,
  input  logic [3:0]                   psum_row,
  input  logic                         first_pass,
  input  logic                         last_pass,
  output logic                         in_ready,
  output logic [OUT_W-1:0]             out_data,
  output logic [3:0]                   out_row,
  output logic [3:0]                   out_col,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic                         frame_done,
  output logic                         err_row
);
  state_t state;
  logic signed [PSUM_W-1:0] acc [ROWS][COLS];
  logic signed [PSUM_W-1:0] sum [COLS];
  logic [COLS-1:0][OUT_W-1:0] drain, pp;
  logic accept, row_ok, beat, col_end, load;
  logic [3:0] ri;
  assign accept = psum_valid & in_ready;
  assign row_ok = psum_row < 4'(ROWS);
  assign ri = row_ok ? psum_row : '0;
  assign load = accept & row_ok & last_pass;
  assign beat = out_valid & out_ready;
  assign col_end = out_col == 4'(COLS-1);
  assign out_last = out_valid & (out_row == 4'(ROWS-1)) & col_end;
  assign out_data = drain[out_col];
  for (genvar c = 0; c < COLS; c++) begin : g_lane
    assign sum[c] = first_pass ? $signed(psum_outs[c]) : sat_add32(acc[ri][c], $signed(psum_outs[c]));
    psum_postproc #(.PSUM_W(PSUM_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_pp (.x(sum[c]), .y(pp[c]));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          acc[r][c] <= '0;
      drain <= '0;
      in_ready <= 1'b0;
      out_row <= '0;
      out_col <= '0;
      out_valid <= 1'b0;
      frame_done <= 1'b0;
      err_row <= 1'b0;
    end else begin
      // accept and beat are exclusive: in_ready is low for the whole drain
      in_ready <= (beat & col_end) | (state != S_DRAIN & !load);
      frame_done <= beat & out_last;
      if (accept & !row_ok) err_row <= 1'b1;
      if (accept & row_ok) begin
        for (int c = 0; c < COLS; c++)
          acc[ri][c] <= sum[c];
        state <= last_pass ? S_DRAIN : S_ACCUM;
      end
      if (load) begin
        drain <= pp;
        out_row <= psum_row;
        out_col <= '0;
        out_valid <= 1'b1;
      end
      if (beat) begin
        if (col_end) begin
          out_valid <= 1'b0;
          state <= S_IDLE;
        end else out_col <= out_col + 4'd1;
      end
    end
  end
endmodule
